// File: rtl/wb_sequencer.sv
// Write-back sequencer: merges ALU results and load returns onto one
// register-file write port, with a one-entry skid and read bypass.
//
// Ports:
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_alu_valid/addr/data       ALU result offered this cycle
//   i_ld_req/i_ld_addr          load issue; i_mem_data returns next cycle
//   o_stall                     upstream must hold (skid occupied)
//   o_wb_en/addr/data           registered register-file write port
//   o_ld_pending(_addr)         load accepted, data not yet on wb_*
//   i_rd_addr_a/b               decode read addresses
//   o_byp_hit_a/b, o_byp_data_a/b  newest in-flight write match
//   o_proto_err                 sticky protocol-violation flag
module wb_sequencer #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_alu_valid,
    input  logic [D-1:0] i_alu_addr,
    input  logic [W-1:0] i_alu_data,
    input  logic         i_ld_req,
    input  logic [D-1:0] i_ld_addr,
    input  logic [W-1:0] i_mem_data,
    output logic         o_stall,
    output logic         o_wb_en,
    output logic [D-1:0] o_wb_addr,
    output logic [W-1:0] o_wb_data,
    output logic         o_ld_pending,
    output logic [D-1:0] o_ld_pending_addr,
    input  logic [D-1:0] i_rd_addr_a,
    input  logic [D-1:0] i_rd_addr_b,
    output logic         o_byp_hit_a,
    output logic         o_byp_hit_b,
    output logic [W-1:0] o_byp_data_a,
    output logic [W-1:0] o_byp_data_b,
    output logic         o_proto_err
);

    logic         r_ld_s1_valid;
    logic [D-1:0] r_ld_s1_addr;
    logic         r_skid_valid;
    logic [D-1:0] r_skid_addr;
    logic [W-1:0] r_skid_data;
    logic         r_wb_en;
    logic [D-1:0] r_wb_addr;
    logic [W-1:0] r_wb_data;
    logic         r_proto_err;

    logic         w_acc_ld;
    logic         w_acc_alu;
    logic         w_viol;
    logic         w_win;
    logic [D-1:0] w_win_addr;
    logic [W-1:0] w_win_data;
    logic         w_skid_set;
    logic         w_skid_clr;

    // When both requests arrive together the load is taken and the ALU
    // request is dropped.
    assign w_acc_ld  = i_ld_req & ~r_skid_valid;
    assign w_acc_alu = i_alu_valid & ~r_skid_valid & ~i_ld_req;

    assign w_viol = (r_skid_valid & (i_alu_valid | i_ld_req))
                  | (~r_skid_valid & i_alu_valid & i_ld_req);

    always_comb begin
        w_win      = 1'b0;
        w_win_addr = '0;
        w_win_data = '0;
        w_skid_set = 1'b0;
        w_skid_clr = 1'b0;
        if (r_ld_s1_valid) begin
            w_win      = 1'b1;
            w_win_addr = r_ld_s1_addr;
            w_win_data = i_mem_data;
            w_skid_set = w_acc_alu;
        end else if (r_skid_valid) begin
            w_win      = 1'b1;
            w_win_addr = r_skid_addr;
            w_win_data = r_skid_data;
            w_skid_clr = 1'b1;
        end else if (w_acc_alu) begin
            w_win      = 1'b1;
            w_win_addr = i_alu_addr;
            w_win_data = i_alu_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ld_s1_valid <= 1'b0;
            r_ld_s1_addr  <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_addr   <= '0;
            r_skid_data   <= '0;
            r_wb_en       <= 1'b0;
            r_wb_addr     <= '0;
            r_wb_data     <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            r_ld_s1_valid <= w_acc_ld;
            if (w_acc_ld)
                r_ld_s1_addr <= i_ld_addr;
            if (w_skid_set) begin
                r_skid_valid <= 1'b1;
                r_skid_addr  <= i_alu_addr;
                r_skid_data  <= i_alu_data;
            end else if (w_skid_clr) begin
                r_skid_valid <= 1'b0;
            end
            r_wb_en <= w_win;
            if (w_win) begin
                r_wb_addr <= w_win_addr;
                r_wb_data <= w_win_data;
            end
            if (w_viol)
                r_proto_err <= 1'b1;
        end
    end

    // Skid holds a younger write than wb_*, so it is checked first.
    always_comb begin
        o_byp_hit_a  = 1'b0;
        o_byp_data_a = '0;
        if (r_skid_valid && r_skid_addr == i_rd_addr_a) begin
            o_byp_hit_a  = 1'b1;
            o_byp_data_a = r_skid_data;
        end else if (r_wb_en && r_wb_addr == i_rd_addr_a) begin
            o_byp_hit_a  = 1'b1;
            o_byp_data_a = r_wb_data;
        end
    end

    always_comb begin
        o_byp_hit_b  = 1'b0;
        o_byp_data_b = '0;
        if (r_skid_valid && r_skid_addr == i_rd_addr_b) begin
            o_byp_hit_b  = 1'b1;
            o_byp_data_b = r_skid_data;
        end else if (r_wb_en && r_wb_addr == i_rd_addr_b) begin
            o_byp_hit_b  = 1'b1;
            o_byp_data_b = r_wb_data;
        end
    end

    assign o_stall           = r_skid_valid;
    assign o_wb_en           = r_wb_en;
    assign o_wb_addr         = r_wb_addr;
    assign o_wb_data         = r_wb_data;
    assign o_ld_pending      = r_ld_s1_valid;
    assign o_ld_pending_addr = r_ld_s1_addr;
    assign o_proto_err       = r_proto_err;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed self-checking bench for wb_sequencer.
// Inputs change 1ns after each rising edge; outputs are checked there.
module tb_wb_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_valid;
    logic [3:0] alu_addr;
    logic [7:0] alu_data;
    logic       ld_req;
    logic [3:0] ld_addr;
    logic [7:0] mem_data;
    logic       stall;
    logic       wb_en;
    logic [3:0] wb_addr;
    logic [7:0] wb_data;
    logic       ld_pending;
    logic [3:0] ld_pending_addr;
    logic [3:0] rd_addr_a;
    logic [3:0] rd_addr_b;
    logic       byp_hit_a;
    logic       byp_hit_b;
    logic [7:0] byp_data_a;
    logic [7:0] byp_data_b;
    logic       proto_err;

    int tests = 0;
    int fails = 0;

    wb_sequencer #(.W(8), .D(4)) dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_alu_valid       (alu_valid),
        .i_alu_addr        (alu_addr),
        .i_alu_data        (alu_data),
        .i_ld_req          (ld_req),
        .i_ld_addr         (ld_addr),
        .i_mem_data        (mem_data),
        .o_stall           (stall),
        .o_wb_en           (wb_en),
        .o_wb_addr         (wb_addr),
        .o_wb_data         (wb_data),
        .o_ld_pending      (ld_pending),
        .o_ld_pending_addr (ld_pending_addr),
        .i_rd_addr_a       (rd_addr_a),
        .i_rd_addr_b       (rd_addr_b),
        .o_byp_hit_a       (byp_hit_a),
        .o_byp_hit_b       (byp_hit_b),
        .o_byp_data_a      (byp_data_a),
        .o_byp_data_b      (byp_data_b),
        .o_proto_err       (proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        ld_req    = 1'b0;
        ld_addr   = '0;
        mem_data  = '0;
    endtask

    initial begin
        reset     = 1'b1;
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd0;
        idle();

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            alu_valid = 1'($urandom);
            alu_addr  = 4'($urandom);
            alu_data  = 8'($urandom);
            ld_req    = 1'($urandom);
            ld_addr   = 4'($urandom);
            mem_data  = 8'($urandom);
            tick();
        end
        idle();
        reset = 1'b0;
        #1;
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_wb_addr", 32'(wb_addr), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ldp", 32'(ld_pending), 32'd0);
        chk("rst_ldp_addr", 32'(ld_pending_addr), 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);
        chk("rst_hit_a", 32'(byp_hit_a), 32'd0);
        chk("rst_byp_a", 32'(byp_data_a), 32'd0);

        // ALU write
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 8'h5A;
        tick();
        idle();
        rd_addr_a = 4'd3;
        rd_addr_b = 4'd4;
        #1;
        chk("alu_wb_en", 32'(wb_en), 32'd1);
        chk("alu_wb_addr", 32'(wb_addr), 32'd3);
        chk("alu_wb_data", 32'(wb_data), 32'h5A);
        chk("alu_hit_a", 32'(byp_hit_a), 32'd1);
        chk("alu_byp_a", 32'(byp_data_a), 32'h5A);
        chk("alu_hit_b", 32'(byp_hit_b), 32'd0);
        chk("alu_byp_b", 32'(byp_data_b), 32'd0);
        chk("alu_stall", 32'(stall), 32'd0);
        tick();
        chk("alu_idle", 32'(wb_en), 32'd0);

        // Load write
        ld_req = 1'b1; ld_addr = 4'd7;
        tick();
        idle();
        mem_data = 8'hC3;
        chk("ld_pend", 32'(ld_pending), 32'd1);
        chk("ld_pend_addr", 32'(ld_pending_addr), 32'd7);
        chk("ld_t1_wb_en", 32'(wb_en), 32'd0);
        tick();
        idle();
        chk("ld_wb_en", 32'(wb_en), 32'd1);
        chk("ld_wb_addr", 32'(wb_addr), 32'd7);
        chk("ld_wb_data", 32'(wb_data), 32'hC3);
        chk("ld_pend_clr", 32'(ld_pending), 32'd0);

        // Back-to-back loads
        ld_req = 1'b1; ld_addr = 4'd1;
        tick();
        ld_addr = 4'd2; mem_data = 8'hA1;
        tick();
        ld_req = 1'b0; mem_data = 8'hA2;
        chk("b2b_wb1_addr", 32'(wb_addr), 32'd1);
        chk("b2b_wb1_data", 32'(wb_data), 32'hA1);
        chk("b2b_pend2", 32'(ld_pending_addr), 32'd2);
        tick();
        idle();
        chk("b2b_wb2_en", 32'(wb_en), 32'd1);
        chk("b2b_wb2_addr", 32'(wb_addr), 32'd2);
        chk("b2b_wb2_data", 32'(wb_data), 32'hA2);

        // Collision on R0
        ld_req = 1'b1; ld_addr = 4'd0;
        tick();
        idle();
        mem_data = 8'h11;
        alu_valid = 1'b1; alu_addr = 4'd0; alu_data = 8'h22;
        tick();
        idle();
        rd_addr_a = 4'd0;
        #1;
        chk("col_t2_addr", 32'(wb_addr), 32'd0);
        chk("col_t2_data", 32'(wb_data), 32'h11);
        chk("col_t2_stall", 32'(stall), 32'd1);
        chk("col_skid_hit", 32'(byp_hit_a), 32'd1);
        chk("col_skid_byp", 32'(byp_data_a), 32'h22);
        tick();
        chk("col_t3_en", 32'(wb_en), 32'd1);
        chk("col_t3_data", 32'(wb_data), 32'h22);
        chk("col_t3_stall", 32'(stall), 32'd0);
        chk("col_r0_byp", 32'(byp_data_a), 32'h22);
        chk("col_perr", 32'(proto_err), 32'd0);
        tick();
        chk("col_idle", 32'(wb_en), 32'd0);

        // Violation: both requests at once
        alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 8'h99;
        ld_req = 1'b1; ld_addr = 4'd6;
        tick();
        idle();
        mem_data = 8'h77;
        chk("vio_perr1", 32'(proto_err), 32'd1);
        chk("vio_t1_en", 32'(wb_en), 32'd0);
        chk("vio_pend", 32'(ld_pending_addr), 32'd6);
        tick();
        idle();
        chk("vio_ld_en", 32'(wb_en), 32'd1);
        chk("vio_ld_addr", 32'(wb_addr), 32'd6);
        chk("vio_ld_data", 32'(wb_data), 32'h77);
        tick();
        chk("vio_no_alu", 32'(wb_en), 32'd0);
        chk("vio_stall", 32'(stall), 32'd0);
        chk("vio_perr_hold", 32'(proto_err), 32'd1);

        // Reset clears sticky error
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_perr", 32'(proto_err), 32'd0);

        // Request during stall is ignored and flagged
        ld_req = 1'b1; ld_addr = 4'd8;
        tick();
        idle();
        mem_data = 8'h44;
        alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 8'h33;
        tick();
        idle();
        alu_valid = 1'b1; alu_addr = 4'd10; alu_data = 8'hEE;
        chk("stl_stall", 32'(stall), 32'd1);
        chk("stl_perr0", 32'(proto_err), 32'd0);
        tick();
        idle();
        chk("stl_skid_addr", 32'(wb_addr), 32'd9);
        chk("stl_skid_data", 32'(wb_data), 32'h33);
        chk("stl_perr1", 32'(proto_err), 32'd1);
        tick();
        chk("stl_dropped", 32'(wb_en), 32'd0);

        // Reset mid-load
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ld_req = 1'b1; ld_addr = 4'd9;
        tick();
        idle();
        reset = 1'b1;
        mem_data = 8'h55;
        tick();
        reset = 1'b0;
        idle();
        mem_data = 8'h66;
        chk("rml_t2_en", 32'(wb_en), 32'd0);
        chk("rml_pend", 32'(ld_pending), 32'd0);
        tick();
        idle();
        chk("rml_t3_en", 32'(wb_en), 32'd0);
        chk("rml_t3_pend", 32'(ld_pending), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Write-back sequencer that drives the single write port of the 8-bit, 16-entry register file. It merges ALU results (ready in the issue cycle) and data-memory loads (data returns one cycle after the request) onto the one write port, preserving program order. A one-entry skid buffer absorbs port collisions. It also publishes a pending-load indication and bypass data for in-flight writes, which decode uses to avoid stale reads.

## Interface
- W, 8, data path width (fixed at 8)
- D, 4, register address width (2**D registers)
- clk  in  1  clock; every register updates on its rising edge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result offered this cycle
- alu_addr  in  D  ALU destination register
- alu_data  in  W  ALU result
- ld_req  in  1  load issued this cycle; memory returns data on the next cycle
- ld_addr  in  D  load destination register
- mem_data  in  W  load data, valid exactly one cycle after an accepted ld_req
- stall  out  1  upstream must hold; alu_valid/ld_req are not accepted while high
- wb_en  out  1  register file write enable (registered)
- wb_addr  out  D  register file write address (registered)
- wb_data  out  W  register file write data (registered)
- ld_pending  out  1  a load is accepted and its data is not yet on wb_*
- ld_pending_addr  out  D  destination of that load
- rd_addr_a, rd_addr_b  in  D  decode read addresses for bypass lookup
- byp_hit_a, byp_hit_b  out  1  newest in-flight write targets rd_addr_a/b
- byp_data_a, byp_data_b  out  W  data of that in-flight write
- proto_err  out  1  sticky; set on a protocol violation, cleared only by reset

## Operation
- **Internal state:**
  - Load stage: ld_s1_valid, ld_s1_addr (request accepted, data due this cycle).
  - Skid: skid_valid, skid_addr, skid_data.
  - Output registers: wb_en, wb_addr, wb_data.
- **Acceptance:**
  - A request is accepted when stall=0.
  - An accepted ld_req loads ld_s1 for the next cycle.
  - An accepted alu_valid becomes a write candidate in the same cycle.
- **Write-port arbitration each cycle** (fixed priority):
  1. Load return: ld_s1_valid, data from mem_data.
  2. Skid entry.
  3. Accepted ALU request.
  - The winner is registered into wb_* at the next edge.
  - An accepted ALU request that loses goes into the skid.
  - The skid entry is never dropped; it is written when no load returns.
- **Ordering:** a load return is always older than a concurrent ALU request, so load-over-ALU priority preserves program order.
- **stall:** equals skid_valid (registered).
- **Protocol violations** (each sets proto_err):
  - alu_valid and ld_req both high while stall=0: the load is accepted and the ALU request is dropped.
  - alu_valid or ld_req high while stall=1: the request is ignored.
- **ld_pending:** equals ld_s1_valid; ld_pending_addr equals ld_s1_addr.
- **Bypass:** for each read port, the newest matching in-flight write wins.
  - Order, newest first: skid entry, then wb_* (wb_en=1).
  - ld_s1 never produces a hit; decode uses ld_pending for it.
  - Lookup is combinational from current state.
  - With no hit, byp_hit=0 and byp_data=0.
- **Address rules:** no special treatment of any register number. Writes to R0 and R7 (the branch-compare registers) are sequenced like any other.

## Timing
- **Reset:** at the edge with reset=1, the following clear to 0 and take effect next cycle:
  - wb_en, wb_addr, wb_data
  - stall, skid_valid, ld_s1_valid
  - ld_pending, ld_pending_addr, proto_err
- **Reset mid-operation:**
  - An in-flight load is discarded; mem_data on the following cycle is ignored.
  - A skid entry is lost.
- **ALU latency:** accepted at cycle t with no collision gives wb_en=1 at t+1.
- **Load latency:** ld_req at t, mem_data sampled at t+1, wb_en=1 at t+2.
- **Collision:** a load returns at t+1 and an ALU request is accepted at t+1.
  - t+2: load data on wb_*, skid_valid=1, stall=1.
  - t+3: ALU data on wb_*, stall=0.
- **Skid blocked:** if ld_s1_valid is still 1 in the cycle the skid would drain, the skid waits one more cycle. No new load can be accepted while stall=1, so the skid drains within 2 cycles.
- **Throughput:** one write per cycle. Back-to-back loads (t, t+1) write at t+2 and t+3.

## Test plan
- **Reset:** hold reset 2 cycles with random inputs -> every output 0 at the cycle after reset; proto_err=0.
- **ALU write:** alu_valid=1, addr=3, data=0x5A at t -> wb_en=1, wb_addr=3, wb_data=0x5A at t+1; byp_hit_a=1 with rd_addr_a=3 at t+1.
- **Load write:**
  - Stimulus: ld_req addr=7 at t; mem_data=0xC3 at t+1.
  - At t+1: ld_pending=1, ld_pending_addr=7.
  - At t+2: wb_addr=7, wb_data=0xC3.
- **Collision:**
  - Stimulus: ld_req addr=0 at t; mem_data=0x11 and alu_valid addr=0 data=0x22 at t+1.
  - At t+2: wb_data=0x11 and stall=1; skid bypass for rd_addr_a=0 gives 0x22.
  - At t+3: wb_data=0x22 and stall=0. R0 ends at 0x22.
- **Violation:**
  - Stimulus: alu_valid and ld_req both high at t.
  - Required: proto_err=1 from t+1 and stays set; load written at t+2; no ALU write.
- **Reset mid-load:** ld_req at t, reset=1 at t+1 -> wb_en=0 at t+2 and t+3; ld_pending=0.
